// File: rtl/alu_issue_stage.sv
// Issue stage in front of a combinational 32-bit ALU: registers operands, captures the result, hands it downstream.
// Optional operand-A forwarding from the last handshaken result is enabled with `define ALU_ISSUE_FWD_EN.
module alu_issue_stage #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int TAG_W  = 5
) (
  input  logic              clock,
  input  logic              reset,
  // Handshakes: a transfer happens on a rising edge where valid & ready are both high.
  // valid never waits on ready; payload is held stable while valid is high and ready is low.
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [DATA_W-1:0] in_rs_val,
  input  logic [DATA_W-1:0] in_rt_val,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic              in_use_imm,
  input  logic [TAG_W-1:0]  in_tag,
`ifdef ALU_ISSUE_FWD_EN
  input  logic [TAG_W-1:0]  in_src_tag,
`endif
  output logic [DATA_W-1:0] alu_A,
  output logic [DATA_W-1:0] alu_B,
  output logic [3:0]        alu_funct,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_flagZ,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_zero,
  output logic [TAG_W-1:0]  res_tag,
  output logic              res_err,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic              accept;
  logic              res_hs;
  logic              op_legal;
  logic              op_shift;
  logic [DATA_W-1:0] a_sel;
  logic [DATA_W-1:0] b_sel;
  logic [TAG_W-1:0]  op_tag;
  logic              op_err;

  assign accept = in_valid & in_ready;
  assign res_hs = res_valid & res_ready;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = EXEC;
      EXEC: state_d = HOLD;
      HOLD: begin
        if (res_hs) state_d = in_valid ? EXEC : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state_q == IDLE) | ((state_q == HOLD) & res_ready);
    res_valid = (state_q == HOLD);
    dbg_state = state_q;
  end

  // Op decode
  always_comb begin
    op_legal = 1'b0;
    op_shift = 1'b0;
    case (in_op)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4: op_legal = 1'b1;
      4'd6, 4'd7, 4'd8: begin
        op_legal = 1'b1;
        op_shift = 1'b1;
      end
      default: op_legal = 1'b0;
    endcase
  end

  // Shift amounts only use the low 5 immediate bits, zero-extended.
  always_comb begin
    if (!in_use_imm)
      b_sel = in_rt_val;
    else if (op_shift)
      b_sel = {{(DATA_W-5){1'b0}}, in_imm[4:0]};
    else
      b_sel = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
  end

`ifdef ALU_ISSUE_FWD_EN
  logic              last_valid;
  logic [TAG_W-1:0]  last_tag;
  logic [DATA_W-1:0] last_data;
  logic              fwd_ok;
  logic [TAG_W-1:0]  fwd_tag;
  logic [DATA_W-1:0] fwd_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_valid <= 1'b0;
      last_tag   <= '0;
      last_data  <= '0;
    end else if (res_hs) begin
      last_valid <= 1'b1;
      last_tag   <= res_tag;
      last_data  <= res_data;
    end
  end

  // A result handshaken on this same edge is the most recent one, so it wins over the stored copy.
  always_comb begin
    if (res_hs) begin
      fwd_ok   = 1'b1;
      fwd_tag  = res_tag;
      fwd_data = res_data;
    end else begin
      fwd_ok   = last_valid;
      fwd_tag  = last_tag;
      fwd_data = last_data;
    end
    if (fwd_ok && (in_src_tag != '0) && (in_src_tag == fwd_tag))
      a_sel = fwd_data;
    else
      a_sel = in_rs_val;
  end
`else
  always_comb begin
    a_sel = in_rs_val;
  end
`endif

  // Operand registers change only on accept, so they stay put while a result is pending.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      alu_A     <= '0;
      alu_B     <= '0;
      alu_funct <= '0;
      op_tag    <= '0;
      op_err    <= 1'b0;
    end else if (accept) begin
      alu_A     <= a_sel;
      alu_B     <= b_sel;
      alu_funct <= op_legal ? in_op : 4'd0;
      op_tag    <= in_tag;
      op_err    <= ~op_legal;
    end
  end

  // Result capture at the end of EXEC; illegal ops report zero data and a clear zero flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      res_data <= '0;
      res_zero <= 1'b0;
      res_tag  <= '0;
      res_err  <= 1'b0;
    end else if (state_q == EXEC) begin
      res_data <= op_err ? '0 : alu_out;
      res_zero <= ~op_err & alu_flagZ;
      res_tag  <= op_tag;
      res_err  <= op_err;
    end
  end

endmodule
